parametrised_in_flight_output_channel_tracker: RTL
==================================================

Name: parametrised_in_flight_output_channel_tracker

Overview:
- Tracks, per output channel, the number of in-flight instructions that target that channel: issued, but not yet enqueued into the channel FIFO.
- Combines these in-flight counts with the live FIFO occupancy to produce precise per-channel full status for the trigger/issue stage.
- Replaces fixed three-stage recomputation with registered up/down counters. Pipeline depth and channel count are arbitrary. Supports squash, a conservative mode and sticky error detection.
- Sits between the output channel FIFOs, the issue stage and the pipeline writeback/flush control.

Parameters:
- NUM_OUTPUT_CHANNELS, 4, number of output channels tracked.
- FIFO_DEPTH, 4, capacity of each output channel FIFO.
- COUNT_WIDTH, 3, width of FIFO occupancy counts; must hold 0..FIFO_DEPTH.
- MAX_IN_FLIGHT, 3, maximum instructions between issue and enqueue (pipeline stages downstream of issue).
- IN_FLIGHT_WIDTH, 2, width of each in-flight counter; must hold 0..MAX_IN_FLIGHT.

Ports:
- clock  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- output_channel_counts  input  [COUNT_WIDTH-1:0] x NUM_OUTPUT_CHANNELS  current FIFO occupancy per channel.
- issue_valid  input  1  an instruction issues this cycle.
- issue_oci  input  NUM_OUTPUT_CHANNELS  one-hot or multi-hot destination channels of the issuing instruction.
- retire_valid  input  1  an instruction enqueues into its output FIFOs at this clock edge.
- retire_oci  input  NUM_OUTPUT_CHANNELS  destination channels of the retiring instruction.
- squash  input  1  pipeline flush; all in-flight instructions are discarded.
- conservative_mode  input  1  any non-zero in-flight count marks the channel full.
- updated_output_channel_full_status  output  NUM_OUTPUT_CHANNELS  per-channel full flag.
- in_flight_counts  output  [IN_FLIGHT_WIDTH-1:0] x NUM_OUTPUT_CHANNELS  registered in-flight counters.
- tracking_error  output  1  sticky flag for counter overflow or underflow.

Behaviour:
- Reset, sampled at the clock edge:
  - all in_flight_counts = 0; tracking_error = 0.
  - full status then reflects output_channel_counts alone (combinational).
- Per channel c, each edge, with reset low:
  - inc = issue_valid & issue_oci[c] & ~squash.
  - dec = retire_valid & retire_oci[c] & ~squash.
- Counter update:
  - squash = 1: counter <= 0. Squash dominates any same-cycle issue or retire.
  - inc & ~dec: counter + 1.
  - dec & ~inc: counter - 1.
  - inc & dec: unchanged.
  - neither: unchanged.
- Saturation and errors:
  - Increment at MAX_IN_FLIGHT saturates (counter held) and sets tracking_error.
  - Decrement at 0 holds the counter at 0 and sets tracking_error.
  - tracking_error clears only on reset.
- Full status is combinational from the registered counters and the live output_channel_counts:
  - conservative_mode = 0: full[c] = (output_channel_counts[c] + in_flight[c]) >= FIFO_DEPTH.
  - The sum is computed at max(COUNT_WIDTH, IN_FLIGHT_WIDTH)+1 bits; no wrap-around is permitted.
  - conservative_mode = 1: full[c] = (in_flight[c] != 0) | (output_channel_counts[c] >= FIFO_DEPTH).
- Latency:
  - An issue at cycle t is reflected in full status from cycle t+1. The issuing instruction's own cycle is the issue stage's responsibility.
  - A retire at edge t decrements the counter in the same edge at which the FIFO count increments, so the instruction is never double-counted or dropped.
- Multi-hot issue_oci / retire_oci: every flagged channel is updated independently.
- conservative_mode may change any cycle; it affects full status combinationally and never affects the counters.

Test Plan:
- Reset, counts = {0,0,0,0}, no issue -> full = 4'b0000, all in_flight = 0, tracking_error = 0.
- Channel 0 count = 2, issue to ch0 in two consecutive cycles -> in_flight[0] = 1 then 2; full[0] = 0 after the first issue, 1 after the second; other channels stay 0.
- Issue and retire ch1 in the same cycle with in_flight[1] = 1 -> in_flight[1] stays 1; retire alone next cycle with count 2->3 -> in_flight[1] = 0, full[1] = 0.
- in_flight = {3,1,0,2}, squash asserted together with issue to ch2 -> next cycle all counters 0, tracking_error = 0.
- in_flight[3] = 3 (MAX_IN_FLIGHT), issue to ch3 -> counter stays 3, tracking_error = 1. Then retire to ch2 with counter 0 -> counter stays 0, error stays 1 until reset.
- conservative_mode = 1, ch0 count 0, in_flight[0] = 1 -> full[0] = 1. Drop conservative_mode -> full[0] = 0 in the same cycle.

Source files
------------

// File: rtl/parametrised_in_flight_output_channel_tracker.sv
// Purpose:
//   Tracks, per output channel, how many issued instructions are still in the
//   pipeline and have not yet been enqueued into that channel's FIFO. These
//   in-flight counts are added to the live FIFO occupancy to give the issue
//   stage a precise per-channel "full" status.
//
// Ports:
//   clock, reset                        - system clock, synchronous active-high reset
//   output_channel_counts               - live FIFO occupancy, channel c at [c*COUNT_WIDTH +: COUNT_WIDTH]
//   issue_valid / issue_oci             - issuing instruction and its (multi-hot) destination channels
//   retire_valid / retire_oci           - instruction enqueuing into its FIFOs at this edge
//   squash                              - pipeline flush, discards every in-flight instruction
//   conservative_mode                   - any in-flight instruction marks its channel full
//   updated_output_channel_full_status  - per-channel full flag (combinational)
//   in_flight_counts                    - registered counters, channel c at [c*IN_FLIGHT_WIDTH +: IN_FLIGHT_WIDTH]
//   tracking_error                      - sticky overflow/underflow flag, cleared only by reset
module parametrised_in_flight_output_channel_tracker #(
  parameter int NUM_OUTPUT_CHANNELS = 4,
  parameter int FIFO_DEPTH          = 4,
  parameter int COUNT_WIDTH         = 3,
  parameter int MAX_IN_FLIGHT       = 3,
  parameter int IN_FLIGHT_WIDTH     = 2
) (
  input  logic                                         clock,
  input  logic                                         reset,
  input  logic [NUM_OUTPUT_CHANNELS*COUNT_WIDTH-1:0]     output_channel_counts,
  input  logic                                         issue_valid,
  input  logic [NUM_OUTPUT_CHANNELS-1:0]                 issue_oci,
  input  logic                                         retire_valid,
  input  logic [NUM_OUTPUT_CHANNELS-1:0]                 retire_oci,
  input  logic                                         squash,
  input  logic                                         conservative_mode,
  output logic [NUM_OUTPUT_CHANNELS-1:0]                 updated_output_channel_full_status,
  output logic [NUM_OUTPUT_CHANNELS*IN_FLIGHT_WIDTH-1:0] in_flight_counts,
  output logic                                         tracking_error
);

  // The sum of occupancy and in-flight count gets one extra bit over the
  // wider operand so it can never wrap before the depth comparison.
  localparam int SUM_WIDTH = ((COUNT_WIDTH > IN_FLIGHT_WIDTH) ? COUNT_WIDTH : IN_FLIGHT_WIDTH) + 1;

  localparam logic [SUM_WIDTH-1:0]       DEPTH_SUM = SUM_WIDTH'(FIFO_DEPTH);
  localparam logic [IN_FLIGHT_WIDTH-1:0] MAX_COUNT = IN_FLIGHT_WIDTH'(MAX_IN_FLIGHT);

  logic [NUM_OUTPUT_CHANNELS-1:0][IN_FLIGHT_WIDTH-1:0] in_flight_q, in_flight_d;
  logic                                                tracking_error_q, tracking_error_d;

  // Counter update. Squash gates both inc and dec, so a flush simply clears
  // every counter and can never raise an error. Simultaneous inc and dec on
  // a channel cancel out, including at the saturation limits.
  always_comb begin
    in_flight_d      = in_flight_q;
    tracking_error_d = tracking_error_q;
    for (int c = 0; c < NUM_OUTPUT_CHANNELS; c++) begin
      logic inc;
      logic dec;
      inc = issue_valid & issue_oci[c] & ~squash;
      dec = retire_valid & retire_oci[c] & ~squash;
      if (squash) begin
        in_flight_d[c] = '0;
      end else if (inc && !dec) begin
        if (in_flight_q[c] == MAX_COUNT) begin
          tracking_error_d = 1'b1;
        end else begin
          in_flight_d[c] = in_flight_q[c] + 1'b1;
        end
      end else if (dec && !inc) begin
        if (in_flight_q[c] == '0) begin
          tracking_error_d = 1'b1;
        end else begin
          in_flight_d[c] = in_flight_q[c] - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      in_flight_q      <= '0;
      tracking_error_q <= 1'b0;
    end else begin
      in_flight_q      <= in_flight_d;
      tracking_error_q <= tracking_error_d;
    end
  end

  // Full status is purely combinational so that a FIFO dequeue or a mode
  // change is visible to the issue stage in the same cycle.
  always_comb begin
    updated_output_channel_full_status = '0;
    for (int c = 0; c < NUM_OUTPUT_CHANNELS; c++) begin
      logic [SUM_WIDTH-1:0] occ;
      logic [SUM_WIDTH-1:0] total;
      occ   = SUM_WIDTH'(output_channel_counts[c*COUNT_WIDTH +: COUNT_WIDTH]);
      total = occ + SUM_WIDTH'(in_flight_q[c]);
      if (conservative_mode) begin
        updated_output_channel_full_status[c] = (in_flight_q[c] != '0) | (occ >= DEPTH_SUM);
      end else begin
        updated_output_channel_full_status[c] = (total >= DEPTH_SUM);
      end
    end
  end

  assign in_flight_counts = in_flight_q;
  assign tracking_error   = tracking_error_q;

endmodule
